// File: rtl/cache_axi_wr_ctrl.sv
// cache_axi_wr_ctrl
//   Write-side AXI master for the cache-to-memory path. Each accepted cache
//   write request (line write-back or uncached byte/half/word write) becomes
//   one AXI write transaction: AW, then 1 or 4 W beats, then B.
//   A combinational read-after-write check tells the read path whether the
//   write in flight touches the same 16-byte line as raw_addr.
// Ports
//   aclk, aresetn                 clock, async active-low reset
//   wr_req/wr_type/wr_addr/
//   wr_wstrb/wr_data/wr_rdy       cache write request (valid/ready)
//   wr_done                       one-cycle pulse on the B handshake
//   raw_addr/raw_hit              read-after-write line-hit check
//   aw*/w*/b*                     AXI write address, data, response channels
module cache_axi_wr_ctrl #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic         wr_done,
    input  logic [31:0]  raw_addr,
    output logic         raw_hit,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]   state;
    logic [1:0]   cnt;
    logic         lat_line;
    logic [1:0]   lat_size;
    logic [31:0]  lat_addr;
    logic [3:0]   lat_wstrb;
    logic [127:0] lat_data;

    // The response ID and status carry no information for the cache.
    logic unused_bresp;
    assign unused_bresp = ^{bid, bresp};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            lat_line  <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= 32'd0;
            lat_wstrb <= 4'd0;
            lat_data  <= 128'd0;
        end else begin
            case (state)
                S_IDLE: if (wr_req) begin
                    lat_line  <= (wr_type == 3'b100);
                    // byte/half map directly; every other non-line code is a word
                    case (wr_type)
                        3'b000:  lat_size <= 2'd0;
                        3'b001:  lat_size <= 2'd1;
                        default: lat_size <= 2'd2;
                    endcase
                    lat_addr  <= wr_addr;
                    lat_wstrb <= wr_wstrb;
                    lat_data  <= wr_data;
                    state     <= S_AW;
                end
                S_AW: if (awready) state <= S_W;
                S_W: if (wready) begin
                    if (wlast) begin
                        cnt   <= 2'd0;
                        state <= S_B;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: if (bvalid) state <= S_IDLE;
            endcase
        end
    end

    // Channel fields come straight from the latched request, so they are
    // stable for as long as the corresponding valid is held.
    assign wr_rdy  = (state == S_IDLE);
    assign awvalid = (state == S_AW);
    assign wvalid  = (state == S_W);
    assign bready  = (state == S_B);
    assign wr_done = bvalid & bready;

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awaddr  = lat_line ? {lat_addr[31:4], 4'b0} : lat_addr;
    assign awlen   = lat_line ? 8'd3 : 8'd0;
    assign awsize  = lat_line ? 3'd2 : {1'b0, lat_size};

    assign wdata   = lat_line ? lat_data[{cnt, 5'b0} +: 32] : lat_data[31:0];
    assign wstrb   = lat_line ? 4'hF : lat_wstrb;
    assign wlast   = (state == S_W) && (cnt == awlen[1:0]);

    assign raw_hit = (state != S_IDLE) && (raw_addr[31:4] == lat_addr[31:4]);

endmodule
